seg_scan_scheduler: RTL
=======================

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1000, clock cycles per brightness step; legal range 2..65535.
REQ-002 SHALL port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL port WR_EN  input  1  digit-pattern write strobe.
REQ-005 SHALL port WR_ADDR  input  3  digit index to write, 0..7.
REQ-006 SHALL port WR_DATA  input  8  segment pattern {a,b,c,d,e,f,g,dp}, 1 = segment on.
REQ-007 SHALL port DIG_MASK  input  8  per-digit enable; bit n enables digit n.
REQ-008 SHALL port BRIGHT  input  4  brightness level, 0..15.
REQ-009 SHALL port SEG_COM  output  8  digit common select, active-low, at most one bit low.
REQ-010 SHALL port SEG_DATA  output  8  segment drive for the selected digit, active-high.
REQ-011 SHALL port CUR_DIGIT  output  3  index of the digit owning the current slot.
REQ-012 SHALL port FRAME_DONE  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 SHALL hold an 8x8 pattern register file; WR_EN=1 writes WR_DATA to entry WR_ADDR at the clock edge.
REQ-014 SHALL register all outputs; a write to the displayed digit is visible on SEG_DATA one cycle after the write edge.
REQ-015 SHALL divide each digit slot into 16 steps (0..15) of STEP_CYCLES cycles, so a slot is 16*STEP_CYCLES cycles.
REQ-016 SHALL implement states IDLE, GUARD, LIT and DARK.
REQ-017 IDLE: entered when DIG_MASK==0; SEG_COM=8'hFF, SEG_DATA=8'h00; the step counter holds at 0.
REQ-018 IDLE -> GUARD (step 0) of the lowest enabled digit, on the cycle after DIG_MASK becomes nonzero.
REQ-019 GUARD: step 0; SEG_COM=8'hFF and SEG_DATA=8'h00 to suppress ghosting.
REQ-020 Step s in 1..15 SHALL be LIT when s<=BRIGHT and DARK otherwise.
REQ-021 LIT: SEG_COM has only bit CUR_DIGIT low; SEG_DATA = pattern[CUR_DIGIT].
REQ-022 DARK: SEG_COM=8'hFF and SEG_DATA=8'h00.
REQ-023 BRIGHT=0 SHALL keep the display dark all slot; BRIGHT=15 SHALL light steps 1..15.
REQ-024 BRIGHT SHALL be sampled at every step boundary; a change takes effect at the next step.
REQ-025 At the end of step 15, the scheduler SHALL go to GUARD of the next enabled digit above CUR_DIGIT, wrapping 7->0, in the same cycle with no extra cycles.
REQ-026 Disabled digits SHALL consume zero cycles.
REQ-027 With a single enabled digit, that digit SHALL occupy every slot.
REQ-028 FRAME_DONE SHALL pulse for one cycle on entry to a slot whose index <= the previous slot's index (wrap), including the single-enabled-digit case.
REQ-029 FRAME_DONE SHALL not pulse on the IDLE->GUARD transition.
REQ-030 Clearing the current digit's mask bit mid-slot SHALL blank outputs the next cycle; the slot timing continues and the next digit is chosen at the slot end.
REQ-031 DIG_MASK becoming 0 mid-slot SHALL enter IDLE on the next cycle.
REQ-032 Mask changes to other digits SHALL affect only the next-digit selection at the slot boundary.
REQ-033 Simultaneous write and slot boundary: the new slot SHALL display the newly written data if its index matches WR_ADDR.

Reset
REQ-034 With Reset=1 at a clock edge: all pattern entries SHALL clear to 8'h00, the step counter to 0, CUR_DIGIT to 0, state to IDLE, SEG_COM to 8'hFF, SEG_DATA to 8'h00 and FRAME_DONE to 0.
REQ-035 Reset SHALL override a concurrent WR_EN, including mid-slot and mid-LIT.
REQ-036 The first cycle after reset release SHALL follow REQ-017/REQ-018 using the current DIG_MASK.

Verification (STEP_CYCLES=4)
REQ-037 Setup: write pattern[0]=8'hFC, DIG_MASK=8'h01, BRIGHT=15. Required: repeating 4 cycles of COM=FF/DATA=00, then 60 cycles of COM=FE/DATA=FC; FRAME_DONE pulses every 64 cycles.
REQ-038 Setup: BRIGHT=0, DIG_MASK=8'hFF. Required: COM stays FF throughout; CUR_DIGIT steps 0..7 every 64 cycles; FRAME_DONE pulses at the 7->0 wrap.
REQ-039 Setup: DIG_MASK=8'h81, BRIGHT=3. Required: slot order 0,7,0,7; each slot lit 12 cycles after a 4-cycle guard; FRAME_DONE pulses only on 7->0.
REQ-040 Setup: write pattern[CUR_DIGIT]=8'h60 during LIT. Required: SEG_DATA=60 on the next cycle, with COM unchanged.
REQ-041 Setup: assert Reset during LIT with WR_EN=1. Required: next cycle COM=FF, DATA=00, CUR_DIGIT=0; all patterns read back as 00 once lit.
REQ-042 Setup: DIG_MASK 8'h0F->8'h00 mid-LIT, then 8'h04. Required: IDLE blank the next cycle; GUARD of digit 2 one cycle after mask=04; no FRAME_DONE on that entry.

Source files
------------

// File: rtl/seg_scan_scheduler.sv
// ============================================================================
// Module   : seg_scan_scheduler
// Purpose  : Multiplexed 8-digit seven-segment scan scheduler with per-digit
//            enable, 16-step PWM brightness and anti-ghosting guard step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_scheduler #(
  parameter int unsigned STEP_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       WR_EN,
  input  logic [2:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic [7:0] DIG_MASK,
  input  logic [3:0] BRIGHT,
  output logic [7:0] SEG_COM,
  output logic [7:0] SEG_DATA,
  output logic [2:0] CUR_DIGIT,
  output logic       FRAME_DONE
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_GUARD = 2'd1;
  localparam logic [1:0]  S_LIT   = 2'd2;
  localparam logic [1:0]  S_DARK  = 2'd3;

  localparam logic [15:0] C_LAST_CYCLE = 16'(STEP_CYCLES - 1);
  localparam logic [3:0]  C_LAST_STEP  = 4'd15;

  // Scan state
  logic [1:0]  state_q, state_d;
  logic [3:0]  step_q,  step_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  cur_q,   cur_d;
  logic        fd_q,    fd_d;

  // Registered outputs
  logic [7:0]  com_q,   com_d;
  logic [7:0]  data_q,  data_d;

  // Pattern register file
  logic [7:0]  pat_q [8];

  // Helpers
  logic [2:0]  low_dig;
  logic [2:0]  next_dig;
  logic        next_found;
  logic [2:0]  probe;
  logic [3:0]  step_inc;
  logic [7:0]  pat_sel;
  logic        lit_now;

  // Lowest enabled digit, used when leaving IDLE
  always_comb begin
    low_dig = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (DIG_MASK[i]) begin
        low_dig = 3'(i);
      end
    end
  end

  // Next enabled digit above the current one, wrapping; offset 8 lands back
  // on the current digit so a lone enabled digit reselects itself
  always_comb begin
    next_dig   = cur_q;
    next_found = 1'b0;
    probe      = cur_q;
    for (int i = 1; i <= 8; i++) begin
      probe = cur_q + 3'(i);
      if (!next_found && DIG_MASK[probe]) begin
        next_dig   = probe;
        next_found = 1'b1;
      end
    end
  end

  // Slot/step sequencing: cycle counter within a step, step within a slot,
  // digit selection at slot end; BRIGHT is sampled only at step boundaries
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    fd_d     = 1'b0;
    step_inc = step_q + 4'd1;
    if (DIG_MASK == 8'h00) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
      cnt_d   = 16'd0;
    end else if (state_q == S_IDLE) begin
      state_d = S_GUARD;
      step_d  = 4'd0;
      cnt_d   = 16'd0;
      cur_d   = low_dig;
    end else if (cnt_q == C_LAST_CYCLE) begin
      cnt_d = 16'd0;
      if (step_q == C_LAST_STEP) begin
        state_d = S_GUARD;
        step_d  = 4'd0;
        cur_d   = next_dig;
        fd_d    = (next_dig <= cur_q);
      end else begin
        step_d  = step_inc;
        state_d = (step_inc <= BRIGHT) ? S_LIT : S_DARK;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Output drive for the upcoming cycle; a same-edge write to the shown
  // digit is forwarded so it appears without waiting for the file update
  always_comb begin
    pat_sel = (WR_EN && (WR_ADDR == cur_d)) ? WR_DATA : pat_q[cur_d];
    lit_now = (state_d == S_LIT) && DIG_MASK[cur_d];
    com_d   = lit_now ? ~(8'h01 << cur_d) : 8'hFF;
    data_d  = lit_now ? pat_sel : 8'h00;
  end

  // Pattern register file; reset wins over a concurrent write
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        pat_q[i] <= 8'h00;
      end
    end else if (WR_EN) begin
      pat_q[WR_ADDR] <= WR_DATA;
    end
  end

  // Scan state and output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      cnt_q   <= 16'd0;
      cur_q   <= 3'd0;
      fd_q    <= 1'b0;
      com_q   <= 8'hFF;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      fd_q    <= fd_d;
      com_q   <= com_d;
      data_q  <= data_d;
    end
  end

  assign SEG_COM    = com_q;
  assign SEG_DATA   = data_q;
  assign CUR_DIGIT  = cur_q;
  assign FRAME_DONE = fd_q;

endmodule

`default_nettype wire
